// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Resolves data-memory wait stalls (with a bounded wait and sticky timeout
// flag), EX-stage control-flow redirects and load-use interlocks, and keeps
// saturating performance counters for stall cycles and redirects.
// Stall/flush/redirect outputs are combinational so that they act on the
// pipeline registers in the same cycle the hazard is seen.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int XLEN        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_redirect_target,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  pc_redirect_target,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_stall,
  output logic             mem_wb_flush,
  output logic [1:0]       state,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  // Wait counter must be able to hold the value MEM_TIMEOUT itself.
  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE    = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic              mem_access_s;
  logic              timeout_hit_s;
  logic              mem_busy_s;
  logic              load_use_s;
  logic              timeout_err_set_s;
  logic              err_r;
  logic [CNT_W-1:0]  stall_cycles_r;
  logic [CNT_W-1:0]  redirect_count_r;

  assign mem_access_s  = mem_MemRead | mem_MemWrite;
  assign timeout_hit_s = (state_r == ST_MEM_WAIT) && (wait_cnt_r == TIMEOUT_VAL);
  assign mem_busy_s    = mem_access_s & ~dmem_ready & ~timeout_hit_s;
  // Only a genuine give-up counts as an error; a late ready on the limit cycle is fine.
  assign timeout_err_set_s = timeout_hit_s & mem_access_s & ~dmem_ready;

  // A load writing x0 never creates a real dependency.
  assign load_use_s = ex_MemRead && (ex_rd_addr != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  // Prioritised hazard resolution: memory freeze, then redirect, then load-use bubble.
  always_comb begin
    pc_stall           = 1'b0;
    pc_redirect        = 1'b0;
    pc_redirect_target = {XLEN{1'b0}};
    if_id_stall        = 1'b0;
    if_id_flush        = 1'b0;
    id_ex_stall        = 1'b0;
    id_ex_flush        = 1'b0;
    ex_mem_stall       = 1'b0;
    ex_mem_flush       = 1'b0;
    mem_wb_stall       = 1'b0;
    mem_wb_flush       = 1'b0;
    if (mem_busy_s) begin
      // Freeze everything up to EX/MEM and feed a bubble into WB.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed.
      pc_redirect        = 1'b1;
      pc_redirect_target = ex_redirect_target;
      if_id_flush        = 1'b1;
      id_ex_flush        = 1'b1;
    end else if (load_use_s) begin
      // Hold the consumer in ID and insert one bubble into EX.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_stall    = 1'b0;
      pc_redirect = 1'b0;
    end
  end

  // Next-state logic for the memory-wait tracker.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mem_busy_s) begin
          state_next_s = ST_MEM_WAIT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_MEM_WAIT;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Consecutive wait-stall counter; never exceeds MEM_TIMEOUT because busy drops at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= {WCNT_W{1'b0}};
    end else if (mem_busy_s) begin
      wait_cnt_r <= wait_cnt_r + WCNT_ONE;
    end else begin
      wait_cnt_r <= {WCNT_W{1'b0}};
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (timeout_err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_r   <= {CNT_W{1'b0}};
      redirect_count_r <= {CNT_W{1'b0}};
    end else begin
      if (pc_stall && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (pc_redirect && (redirect_count_r != CNT_MAX)) begin
        redirect_count_r <= redirect_count_r + CNT_ONE;
      end else begin
        redirect_count_r <= redirect_count_r;
      end
    end
  end

  assign state           = state_r;
  assign mem_timeout_err = err_r;
  assign stall_cycles    = stall_cycles_r;
  assign redirect_count  = redirect_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the
// single-cycle priority logic plus hand-written sequences for memory
// waits, timeout and reset-during-wait.
module tb_pipeline_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  // Control bit order: pc_stall, pc_redirect, if_id_stall, if_id_flush,
  // id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush
  localparam logic [9:0] C_NONE = 10'b0000000000;
  localparam logic [9:0] C_LU   = 10'b1010010000;
  localparam logic [9:0] C_RD   = 10'b0101010000;
  localparam logic [9:0] C_FZ   = 10'b1010101001;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_MemRead;
  logic [4:0]       ex_rd_addr;
  logic             ex_redirect;
  logic [XLEN-1:0]  ex_redirect_target;
  logic             mem_MemRead;
  logic             mem_MemWrite;
  logic             dmem_ready;
  logic             pc_stall;
  logic             pc_redirect;
  logic [XLEN-1:0]  pc_redirect_target;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             ex_mem_flush;
  logic             mem_wb_stall;
  logic             mem_wb_flush;
  logic [1:0]       state;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] redirect_count;
  logic [9:0]       ctl;

  int n_checks;
  int n_errors;
  int exp_stall;
  int exp_redir;

  typedef struct {
    logic        ex_mr;
    logic [4:0]  ex_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        redir;
    logic [31:0] tgt;
    logic        mrd;
    logic        mwr;
    logic        rdy;
    logic [9:0]  exp_ctl;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[12];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W), .XLEN(XLEN)) dut (
    .clk                (clk),
    .reset              (reset),
    .id_rs1_addr        (id_rs1_addr),
    .id_rs2_addr        (id_rs2_addr),
    .id_uses_rs1        (id_uses_rs1),
    .id_uses_rs2        (id_uses_rs2),
    .ex_MemRead         (ex_MemRead),
    .ex_rd_addr         (ex_rd_addr),
    .ex_redirect        (ex_redirect),
    .ex_redirect_target (ex_redirect_target),
    .mem_MemRead        (mem_MemRead),
    .mem_MemWrite       (mem_MemWrite),
    .dmem_ready         (dmem_ready),
    .pc_stall           (pc_stall),
    .pc_redirect        (pc_redirect),
    .pc_redirect_target (pc_redirect_target),
    .if_id_stall        (if_id_stall),
    .if_id_flush        (if_id_flush),
    .id_ex_stall        (id_ex_stall),
    .id_ex_flush        (id_ex_flush),
    .ex_mem_stall       (ex_mem_stall),
    .ex_mem_flush       (ex_mem_flush),
    .mem_wb_stall       (mem_wb_stall),
    .mem_wb_flush       (mem_wb_flush),
    .state              (state),
    .mem_timeout_err    (mem_timeout_err),
    .stall_cycles       (stall_cycles),
    .redirect_count     (redirect_count)
  );

  assign ctl = {pc_stall, pc_redirect, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_MemRead = 1'b0; ex_rd_addr = 5'd0; ex_redirect = 1'b0; ex_redirect_target = 32'd0;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    ex_MemRead = v.ex_mr; ex_rd_addr = v.ex_rd; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; ex_redirect = v.redir; ex_redirect_target = v.tgt;
    mem_MemRead = v.mrd; mem_MemWrite = v.mwr; dmem_ready = v.rdy;
  endtask

  // Pulse reset between tests; leaves us just after a rising edge.
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Access already pending with dmem_ready low: expect 16 stall cycles then release.
  task automatic timeout_seq(input logic ready_last);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("tmo_stall", 32'(pc_stall), 32'd1);
      chk("tmo_state", 32'(state), (i == 1) ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
    end
    if (ready_last) dmem_ready = 1'b1;
    @(negedge clk);
    chk("tmo_release_ctl", 32'(ctl), 32'(C_NONE));
    chk("tmo_release_state", 32'(state), 32'd1);
    @(posedge clk);
    #1;
    mem_MemRead = 1'b0;
    dmem_ready  = 1'b0;
    chk("tmo_err", 32'(mem_timeout_err), 32'(!ready_last));
    chk("tmo_state_after", 32'(state), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //          ex_mr  rd     rs1    rs2    u1    u2    redir tgt            mrd   mwr   rdy   exp_ctl exp_tgt
    vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[1]  = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, C_LU,   32'h0};
    vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[3]  = '{1'b1, 5'd7,  5'd7,  5'd3,  1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, C_LU,   32'h0};
    vecs[4]  = '{1'b1, 5'd7,  5'd7,  5'd3,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[5]  = '{1'b0, 5'd7,  5'd7,  5'd7,  1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[6]  = '{1'b1, 5'd5,  5'd0,  5'd5,  1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, C_RD,   32'h0000_0100};
    vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'hDEAD_BEEC, 1'b0, 1'b0, 1'b0, C_RD,   32'hDEAD_BEEC};
    vecs[8]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0, C_FZ,   32'h0};
    vecs[9]  = '{1'b1, 5'd9,  5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, C_LU,   32'h0};
    vecs[10] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, C_NONE, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, C_NONE, 32'h0};

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_err", 32'(mem_timeout_err), 32'd0);
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_redir_cnt", redirect_count, 32'd0);
    chk("rst_ctl", 32'(ctl), 32'(C_NONE));

    // Table of single-cycle priority cases, each followed by an idle cycle.
    exp_stall = 0;
    exp_redir = 0;
    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp_ctl));
      chk($sformatf("vec%0d_tgt", i), pc_redirect_target, vecs[i].exp_tgt);
      @(posedge clk);
      #1;
      exp_stall = exp_stall + int'(vecs[i].exp_ctl[9]);
      exp_redir = exp_redir + int'(vecs[i].exp_ctl[8]);
      chk($sformatf("vec%0d_stall_cnt", i), stall_cycles, 32'(exp_stall));
      chk($sformatf("vec%0d_redir_cnt", i), redirect_count, 32'(exp_redir));
      idle_inputs();
      @(posedge clk);
      #1;
    end

    // Three-cycle memory wait with a redirect held pending behind it.
    pulse_reset();
    mem_MemRead = 1'b1;
    dmem_ready = 1'b0;
    ex_redirect = 1'b1;
    ex_redirect_target = 32'h0000_0200;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("wait_ctl", 32'(ctl), 32'(C_FZ));
      chk("wait_tgt", pc_redirect_target, 32'd0);
      chk("wait_state", 32'(state), (c == 0) ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("release_ctl", 32'(ctl), 32'(C_RD));
    chk("release_tgt", pc_redirect_target, 32'h0000_0200);
    chk("release_state", 32'(state), 32'd1);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("after_wait_state", 32'(state), 32'd0);
    chk("after_wait_err", 32'(mem_timeout_err), 32'd0);
    chk("after_wait_stall_cnt", stall_cycles, 32'd3);
    chk("after_wait_redir_cnt", redirect_count, 32'd1);

    // Memory never responds: bounded stall and sticky error.
    pulse_reset();
    mem_MemRead = 1'b1;
    dmem_ready = 1'b0;
    timeout_seq(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 32'(mem_timeout_err), 32'd1);
    chk("tmo_stall_cnt", stall_cycles, 32'd16);

    // Reset on wait cycle 5 while the error is still set, then a full restart
    // with dmem_ready arriving exactly on the limit cycle.
    mem_MemRead = 1'b1;
    dmem_ready = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("pre_rst_state", 32'(state), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_stall_cnt", stall_cycles, 32'd0);
    chk("midrst_redir_cnt", redirect_count, 32'd0);
    chk("midrst_err", 32'(mem_timeout_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    timeout_seq(1'b1);
    chk("restart_stall_cnt", stall_cycles, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: max consecutive data-memory wait-stall cycles before forced release.
REQ-002 SHALL have parameter CNT_W, default 32: width of performance counters.
REQ-003 SHALL have ports: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-004 SHALL have ports: id_rs1_addr, id_rs2_addr input 5 each, ID-stage source regs; id_uses_rs1, id_uses_rs2 input 1 each, source actually read.
REQ-005 SHALL have ports: ex_MemRead input 1, EX holds a load; ex_rd_addr input 5, EX destination.
REQ-006 SHALL have ports: ex_redirect input 1, taken branch/jal/jalr resolved in EX; ex_redirect_target input XLEN, new PC.
REQ-007 SHALL have ports: mem_MemRead, mem_MemWrite input 1 each, MEM-stage access; dmem_ready input 1, data memory completes access this cycle.
REQ-008 SHALL have ports: pc_stall, pc_redirect output 1 each; pc_redirect_target output XLEN.
REQ-009 SHALL have ports: if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush output 1 each, to pipeline registers.
REQ-010 SHALL have ports: state output 2 (00 RUN, 01 MEM_WAIT); mem_timeout_err output 1, sticky; stall_cycles, redirect_count output CNT_W each.

Function
REQ-011 Stall/flush/redirect outputs SHALL be combinational from inputs and registered state (same-cycle effect on pipeline registers).
REQ-012 mem_busy SHALL = (mem_MemRead|mem_MemWrite) & !dmem_ready & !timeout_hit; timeout_hit = (state==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT).
REQ-013 load_use SHALL = ex_MemRead & ex_rd_addr!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
REQ-014 Priority 1, mem_busy: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall =1; mem_wb_flush=1; all other outputs 0; ex_redirect and load_use ignored this cycle.
REQ-015 Priority 2, ex_redirect (no mem_busy): pc_redirect=1, pc_redirect_target=ex_redirect_target, if_id_flush=1, id_ex_flush=1; load_use ignored.
REQ-016 Priority 3, load_use only: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble per cycle hazard persists).
REQ-017 No hazard: all stall/flush/redirect outputs 0; pc_redirect_target SHALL be 0 whenever pc_redirect=0.
REQ-018 SHALL never assert stall and flush of the same register in one cycle; ex_mem_flush and mem_wb_stall SHALL always be 0.
REQ-019 FSM: RUN->MEM_WAIT when mem_busy; MEM_WAIT->RUN when !mem_busy; otherwise hold.
REQ-020 wait_cnt SHALL increment each cycle mem_busy=1 and clear to 0 each cycle mem_busy=0; width ceil(log2(MEM_TIMEOUT+1)).
REQ-021 A single access SHALL stall at most MEM_TIMEOUT consecutive cycles; on timeout_hit with !dmem_ready, stalls drop, mem_timeout_err sets, state returns RUN.
REQ-022 dmem_ready arriving on the timeout_hit cycle SHALL NOT set mem_timeout_err.
REQ-023 mem_timeout_err SHALL remain 1 until reset.
REQ-024 stall_cycles SHALL increment on each cycle pc_stall=1; redirect_count on each cycle pc_redirect=1; both saturate at all-ones.

Reset
REQ-025 On reset: state=RUN, wait_cnt=0, mem_timeout_err=0, stall_cycles=0, redirect_count=0; asynchronous assertion, synchronous-to-clk deassertion behaviour by design of flops.
REQ-026 Reset asserted mid-MEM_WAIT SHALL return to RUN immediately; first cycle after reset a pending access restarts wait_cnt from 0.

Verification
REQ-027 Load-use: ex_MemRead=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 one cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle, stall_cycles=1.
REQ-028 x0 load: same with ex_rd=0 -> no stall, counters unchanged.
REQ-029 Redirect plus load_use same cycle, target 0x0000_0100 -> pc_redirect=1, target 0x100, if_id_flush=id_ex_flush=1, pc_stall=0, redirect_count=1.
REQ-030 mem_MemRead=1, dmem_ready low 3 cycles then high -> 3 cycles full freeze with mem_wb_flush=1, state 01 during wait, back to 00, err=0; concurrent ex_redirect acted on only after release.
REQ-031 dmem_ready never rises, MEM_TIMEOUT=16 -> exactly 16 stall cycles, 17th cycle stalls 0, mem_timeout_err=1 and stays 1 until reset.
REQ-032 Reset pulse on wait cycle 5 -> state=00, counters 0, err 0 immediately; wait restarts at 0 after release.
